// File: rtl/sync_pulse_pkg.sv
// sync_pulse_pkg: edge-mode encodings and width helper shared by sync_pulse_multi.
package sync_pulse_pkg;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/sync_filt_chan.sv
// sync_filt_chan: one channel of sync chain, stability filter, edge pulse and saturating counter.
module sync_filt_chan
    import sync_pulse_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 1,
    parameter int EDGE_MODE   = EDGE_RISE,
    parameter int CNT_W       = 8
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             cnt_clr,
    output logic             level_out,
    output logic             pulse_out,
    output logic [CNT_W-1:0] evt_cnt
);
    localparam int FW = clog2(FILT_CYC + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FW-1:0]          filt_q, filt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d, pulse_q, pulse_d, differ, accept;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("sync_filt_chan: SYNC_STAGES must be 2..4");
    end
    if (FILT_CYC < 1 || FILT_CYC > 255) begin : g_bad_filt
        $error("sync_filt_chan: FILT_CYC must be 1..255");
    end

    // A level is accepted once the synchronised value has differed for FILT_CYC cycles in a row.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
        differ  = sync_q[SYNC_STAGES-1] != level_q;
        accept  = differ && int'(filt_q) + 1 == FILT_CYC;
        filt_d  = (differ && !accept) ? filt_q + FW'(1) : '0;
        level_d = level_q ^ accept;
        pulse_d = accept && (EDGE_MODE == EDGE_BOTH || (EDGE_MODE == EDGE_FALL) == level_q);
        cnt_d   = cnt_clr ? CNT_W'(pulse_d) : cnt_q + CNT_W'(pulse_d && cnt_q != '1);
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            sync_q  <= '0;
            filt_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            filt_q  <= filt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_out = level_q;
    assign pulse_out = pulse_q;
    assign evt_cnt   = cnt_q;
endmodule

// File: rtl/sync_pulse_multi.sv
// sync_pulse_multi: CH independent async levels synchronised into clk_fast as filtered levels,
// one-cycle edge pulses and saturating event counts.
module sync_pulse_multi
    import sync_pulse_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 1,
    parameter int EDGE_MODE   = EDGE_RISE,
    parameter int CNT_W       = 8
) (
    input  logic                clk_fast,
    input  logic                rst,
    input  logic [CH-1:0]       signal_in,
    input  logic [CH-1:0]       cnt_clr,
    output logic [CH-1:0]       level_out,
    output logic [CH-1:0]       pulse_out,
    output logic                any_pulse,
    output logic [CH*CNT_W-1:0] evt_cnt
);
    if (EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH) begin : g_bad_mode
        $error("sync_pulse_multi: EDGE_MODE must be 0, 1 or 2");
    end
    if (CH < 1 || CH > 32 || CNT_W < 1 || CNT_W > 16) begin : g_bad_size
        $error("sync_pulse_multi: CH must be 1..32 and CNT_W 1..16");
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        sync_filt_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_CYC   (FILT_CYC),
            .EDGE_MODE  (EDGE_MODE),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk_fast (clk_fast),
            .rst      (rst),
            .sig_in   (signal_in[c]),
            .cnt_clr  (cnt_clr[c]),
            .level_out(level_out[c]),
            .pulse_out(pulse_out[c]),
            .evt_cnt  (evt_cnt[c*CNT_W +: CNT_W])
        );
    end

    assign any_pulse = |pulse_out;
endmodule

// File: tb/tb_sync_pulse_multi.sv
// tb_sync_pulse_multi: two configurations (defaults; FILT_CYC=4/both edges/CNT_W=2) against a latency scoreboard.
module tb_sync_pulse_multi;
    typedef struct {
        int   due;
        int   d;
        int   ch;
        logic lvl;
    } ev_t;

    logic        clk_fast = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sig_a = '0, sig_b = '0, clr_a = '0, clr_b = '0;
    logic [3:0]  lvl_a, lvl_b, pul_a, pul_b;
    logic        any_a, any_b;
    logic [31:0] evt_a;
    logic [7:0]  evt_b;

    int   checks = 0, failures = 0, cyc = 0;
    ev_t  sb[$];
    logic [3:0] lvl_m[2], acc_m[2], pul_m[2];
    int   cnt_m[2][4];
    int   lat[2]  = '{3, 6};
    int   mode[2] = '{0, 2};
    int   maxc[2] = '{255, 3};
    int   sat_exp[5] = '{1, 2, 3, 3, 3};

    sync_pulse_multi dut_a (
        .clk_fast(clk_fast), .rst(rst), .signal_in(sig_a), .cnt_clr(clr_a),
        .level_out(lvl_a), .pulse_out(pul_a), .any_pulse(any_a), .evt_cnt(evt_a)
    );

    sync_pulse_multi #(.FILT_CYC(4), .EDGE_MODE(2), .CNT_W(2)) dut_b (
        .clk_fast(clk_fast), .rst(rst), .signal_in(sig_b), .cnt_clr(clr_b),
        .level_out(lvl_b), .pulse_out(pul_b), .any_pulse(any_b), .evt_cnt(evt_b)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A change held long enough is scheduled to appear lat[d] edges after it is driven.
    task automatic drive(input int d, input logic [3:0] v, input bit held);
        for (int c = 0; c < 4; c++) begin
            if (held && v[c] != acc_m[d][c]) begin
                sb.push_back('{cyc + lat[d], d, c, v[c]});
                acc_m[d][c] = v[c];
            end
        end
        if (d == 0) sig_a = v;
        else sig_b = v;
    endtask

    task automatic tick();
        logic [3:0]  clr;
        logic [31:0] ea;
        logic [7:0]  eb;
        @(posedge clk_fast);
        cyc++;
        #1;
        if (rst) begin
            sb.delete();
            for (int d = 0; d < 2; d++) begin
                lvl_m[d] = '0;
                acc_m[d] = '0;
                pul_m[d] = '0;
                for (int c = 0; c < 4; c++) cnt_m[d][c] = 0;
            end
        end else begin
            pul_m[0] = '0;
            pul_m[1] = '0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    lvl_m[sb[i].d][sb[i].ch] = sb[i].lvl;
                    if (mode[sb[i].d] == 2 || (mode[sb[i].d] == 0) == sb[i].lvl)
                        pul_m[sb[i].d][sb[i].ch] = 1'b1;
                    sb.delete(i);
                end
            end
            for (int d = 0; d < 2; d++) begin
                clr = (d == 0) ? clr_a : clr_b;
                for (int c = 0; c < 4; c++)
                    cnt_m[d][c] = clr[c] ? int'(pul_m[d][c]) :
                                  cnt_m[d][c] + ((pul_m[d][c] && cnt_m[d][c] < maxc[d]) ? 1 : 0);
            end
        end
        for (int c = 0; c < 4; c++) begin
            ea[c*8 +: 8] = 8'(cnt_m[0][c]);
            eb[c*2 +: 2] = 2'(cnt_m[1][c]);
        end
        check("level_a", 32'(lvl_a), 32'(lvl_m[0]));
        check("pulse_a", 32'(pul_a), 32'(pul_m[0]));
        check("any_a", 32'(any_a), 32'(|pul_m[0]));
        check("evt_a", evt_a, ea);
        check("level_b", 32'(lvl_b), 32'(lvl_m[1]));
        check("pulse_b", 32'(pul_b), 32'(pul_m[1]));
        check("any_b", 32'(any_b), 32'(|pul_m[1]));
        check("evt_b", 32'(evt_b), 32'(eb));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        run(3);
        check("reset_pulse_a", 32'(pul_a), 32'h0);
        check("reset_evt_a", evt_a, 32'h0);
        rst = 1'b0;
        run(2);

        // Single rising edge, default configuration
        drive(0, 4'b0001, 1'b1);
        run(2);
        check("t1_pulse_early", 32'(pul_a), 32'h0);
        run(1);
        check("t1_pulse_edge3", 32'(pul_a), 32'h1);
        check("t1_level_edge3", 32'(lvl_a), 32'h1);
        run(1);
        check("t1_pulse_width", 32'(pul_a), 32'h0);
        run(6);
        check("t1_evt", evt_a, 32'h0000_0001);

        // Glitch shorter than FILT_CYC, then a real edge
        drive(1, 4'b0010, 1'b0);
        run(3);
        drive(1, 4'b0000, 1'b1);
        run(6);
        check("t2_glitch_level", 32'(lvl_b), 32'h0);
        check("t2_glitch_evt", 32'(evt_b), 32'h0);
        drive(1, 4'b0010, 1'b1);
        run(5);
        check("t2_pulse_early", 32'(pul_b), 32'h0);
        run(1);
        check("t2_pulse_edge6", 32'(pul_b), 32'h2);
        check("t2_evt", 32'(evt_b[3:2]), 32'h1);
        run(4);

        // Both-edge mode
        drive(1, 4'b0110, 1'b1);
        run(6);
        check("t3_any_rise", 32'(any_b), 32'h1);
        check("t3_evt_rise", 32'(evt_b[5:4]), 32'h1);
        run(2);
        drive(1, 4'b0010, 1'b1);
        run(6);
        check("t3_any_fall", 32'(any_b), 32'h1);
        check("t3_evt_fall", 32'(evt_b[5:4]), 32'h2);
        run(2);

        // Saturation at 2-bit width, then clear coinciding with an event
        for (int k = 0; k < 5; k++) begin
            drive(1, sig_b ^ 4'b1000, 1'b1);
            run(6);
            check("t4_sat", 32'(evt_b[7:6]), 32'(sat_exp[k]));
            run(2);
        end
        drive(1, sig_b ^ 4'b1000, 1'b1);
        run(5);
        clr_b[3] = 1'b1;
        run(1);
        clr_b[3] = 1'b0;
        check("t4_clr_event", 32'(evt_b[7:6]), 32'h1);
        check("t4_clr_pulse", 32'(pul_b[3]), 32'h1);
        run(3);

        // Reset mid-operation with all inputs high
        rst = 1'b1;
        sig_a = 4'hF;
        sig_b = 4'hF;
        run(3);
        check("t5_rst_level", 32'({lvl_a, lvl_b}), 32'h0);
        check("t5_rst_evt", evt_a, 32'h0);
        rst = 1'b0;
        drive(0, 4'hF, 1'b1);
        drive(1, 4'hF, 1'b1);
        run(3);
        check("t5_pulse_a", 32'(pul_a), 32'hF);
        check("t5_evt_a", evt_a, 32'h0101_0101);
        run(3);
        check("t5_pulse_b", 32'(pul_b), 32'hF);
        check("t5_evt_b", 32'(evt_b), 32'h55);
        run(2);

        // Random multi-channel toggles
        clr_a = 4'hF;
        clr_b = 4'hF;
        run(1);
        clr_a = '0;
        clr_b = '0;
        for (int k = 0; k < 24; k++) begin
            drive(0, 4'($urandom), 1'b1);
            drive(1, 4'($urandom), 1'b1);
            run(6 + int'($urandom_range(0, 3)));
        end
        run(8);
        check("sb_drained", sb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
